ts_packet_gen: RTL
==================

Name: ts_packet_gen

Overview:
- Transmit-side counterpart of the TS sync recovery receiver.
- Packs a raw payload byte stream into 188-byte MPEG-2 TS packets, one byte per tx_en strobe, each packet starting with sync byte 0x47.
- Inserts null packets when no payload is pending, so the downstream receiver sees an unbroken 188-byte sync cadence.
- Sits between the payload source (encoder/mux FIFO) and the serial/parallel TS output stage.

Parameters:
- PID, 13'h0100, PID placed in data-packet headers (must not be 13'h1FFF).
- PKT_LEN, 188, total packet length in bytes, header included.
- HDR_LEN, 4, header bytes per packet; payload = PKT_LEN-HDR_LEN = 184.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-low reset.
- tx_en  input  1  output rate strobe; one byte is emitted per clk with tx_en=1.
- s_data  input  8  payload byte.
- s_valid  input  1  s_data valid.
- s_pusi  input  1  payload-unit-start flag; sampled at the packet-start decision.
- s_ready  output  1  combinational; = tx_en && state==PAYLOAD. Transfer when s_valid && s_ready.
- byte_out  output  8  TS byte, registered.
- byte_valid  output  1  byte_out valid, registered.
- sop  output  1  high with the 0x47 byte of every packet.
- underrun  output  1  one-cycle pulse when a payload stuffing byte is emitted.

Behaviour:
- Reset (async, rst=0):
  - byte_out=0x00, byte_valid=0, sop=0, underrun=0.
  - CC=0, byte index=0, state=IDLE.
  - Applies instantly, including mid-packet. The partial packet is abandoned, and the next packet starts with a fresh sync byte after release.
- Timing and counting:
  - All outputs update only on clk edges where tx_en=1. Otherwise byte_valid=0 and other outputs hold.
  - Latency: 1 clk from tx_en to byte_valid/byte_out.
  - 8-bit byte index counts 0..PKT_LEN-1 and wraps to 0. Only advances on tx_en.
- State machine:
  - IDLE: packet boundary. On tx_en:
    - s_valid=1: latch s_pusi, go to HDR as a data packet.
    - s_valid=0: go to HDR as a null packet.
    - The decision and byte 0 emission happen on the same edge.
  - HDR: emits header bytes, index 0..3.
    - Data packet:
      - byte 0 = 0x47.
      - byte 1 = {1'b0, pusi, 1'b0, PID[12:8]}.
      - byte 2 = PID[7:0].
      - byte 3 = {2'b00, 2'b01, CC}.
    - Null packet: bytes are 0x47, 0x1F, 0xFF, 0x10.
    - After index 3, go to PAYLOAD (data packet) or NULL (null packet).
  - PAYLOAD: index 4..187.
    - s_valid=1: byte_out=s_data, consumed.
    - s_valid=0: byte_out=0xFF, underrun pulses, nothing consumed.
    - After index 187, go to IDLE.
  - NULL: index 4..187 emit 0xFF. s_ready=0. After index 187, go to IDLE.
- Continuity counter:
  - CC increments mod 16 (15 wraps to 0) once per completed data packet.
  - Null packets never change CC.
- sop=1 exactly on index-0 bytes.
- No pause in tx_en cadence: back-to-back packets, so byte 0 follows byte 187 on the next tx_en.
- Simultaneous events:
  - s_valid rising during HDR or NULL is ignored until the next IDLE decision.
  - s_pusi is only sampled in IDLE.
- tx_en low mid-packet: the packet freezes, with no bytes lost and no stuffing inserted.

Optional Feature:
- Macro: TS_NULL_FILL_EN.
- Defined: null-packet insertion as described above, giving a constant-rate output.
- Undefined:
  - IDLE with s_valid=0 emits nothing (byte_valid=0) and waits. NULL state is not built.
  - Only data packets are ever produced. Mid-packet underrun stuffing with 0xFF is still applied.

Test Plan:
- Reset then tx_en=1, s_valid=1, s_pusi=1, PID=0x0100 -> first 4 bytes 0x47,0x41,0x00,0x10. sop on byte 0. Bytes 4..187 equal the input data. s_ready high for exactly 184 cycles.
- 17 consecutive data packets -> byte 3 sequence 0x10,0x11,...,0x1F,0x10 (CC wraps). Each sync byte is exactly 188 byte_valid cycles apart.
- s_valid=0 at boundary (TS_NULL_FILL_EN defined) -> packet 0x47,0x1F,0xFF,0x10 then 184×0xFF. CC unchanged for the following data packet. Without the macro: byte_valid stays 0 until s_valid=1.
- s_valid dropped for 3 cycles at payload index 50 -> three 0xFF bytes, three underrun pulses, and the packet still ends at index 187 with the next sync 188 bytes later.
- tx_en toggled 1/0 every cycle -> byte_valid every other cycle and identical byte sequence to the continuous case. rst asserted at index 100 -> outputs 0 immediately, and after release the first byte is 0x47 with CC=0.
- Loopback into sync_recovery with 12 packets -> valid_packet asserts after lock. No false loss of sync across null/data packet transitions.

Source files
------------

// File: rtl/ts_packet_gen.sv
// Packs a payload byte stream into 188-byte MPEG-2 TS packets, one byte per tx_en strobe.
// Define TS_NULL_FILL_EN to emit null packets whenever no payload is pending at a packet boundary.
module ts_packet_gen #(
  parameter logic [12:0] PID     = 13'h0100,
  parameter int          PKT_LEN = 188,
  parameter int          HDR_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_en,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_pusi,
  output logic       s_ready,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       sop,
  output logic       underrun
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] HDR      = 2'd1;
  localparam logic [1:0] PAYLOAD  = 2'd2;
  localparam logic [7:0] LAST_IDX = 8'(PKT_LEN - 1);
  localparam logic [7:0] LAST_HDR = 8'(HDR_LEN - 1);

`ifdef TS_NULL_FILL_EN
  localparam logic [1:0] NULL_PKT = 2'd3;
  localparam bit         FILL_EN  = 1'b1;
`else
  localparam bit         FILL_EN  = 1'b0;
`endif

  logic [1:0] state;
  logic [7:0] idx;
  logic [3:0] cc;
  logic       pusi;
  logic       null_pkt;
  logic [7:0] hdr_byte;

  assign s_ready = tx_en && (state == PAYLOAD);

  // Header bytes 1..3; byte 0 (sync) is emitted directly from IDLE.
  always_comb begin
    hdr_byte = 8'h47;
    case (idx[1:0])
      2'd1:    hdr_byte = null_pkt ? 8'h1F : {1'b0, pusi, 1'b0, PID[12:8]};
      2'd2:    hdr_byte = null_pkt ? 8'hFF : PID[7:0];
      2'd3:    hdr_byte = null_pkt ? 8'h10 : {4'b0001, cc};
      default: hdr_byte = 8'h47;
    endcase
  end

`ifndef TS_NULL_FILL_EN
  assign null_pkt = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      idx        <= 8'd0;
      cc         <= 4'd0;
      pusi       <= 1'b0;
`ifdef TS_NULL_FILL_EN
      null_pkt   <= 1'b0;
`endif
      byte_out   <= 8'h00;
      byte_valid <= 1'b0;
      sop        <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (tx_en) begin
        case (state)
          IDLE: begin
            if (s_valid || FILL_EN) begin
              pusi       <= s_pusi;
`ifdef TS_NULL_FILL_EN
              null_pkt   <= !s_valid;
`endif
              byte_out   <= 8'h47;
              byte_valid <= 1'b1;
              sop        <= 1'b1;
              underrun   <= 1'b0;
              idx        <= 8'd1;
              state      <= HDR;
            end
          end
          HDR: begin
            byte_out   <= hdr_byte;
            byte_valid <= 1'b1;
            sop        <= 1'b0;
            underrun   <= 1'b0;
            idx        <= idx + 8'd1;
            if (idx == LAST_HDR) begin
`ifdef TS_NULL_FILL_EN
              state <= null_pkt ? NULL_PKT : PAYLOAD;
`else
              state <= PAYLOAD;
`endif
            end
          end
          PAYLOAD: begin
            // Missing payload is stuffed with 0xFF so the packet length never changes.
            byte_out   <= s_valid ? s_data : 8'hFF;
            byte_valid <= 1'b1;
            sop        <= 1'b0;
            underrun   <= !s_valid;
            if (idx == LAST_IDX) begin
              idx   <= 8'd0;
              cc    <= cc + 4'd1;
              state <= IDLE;
            end else begin
              idx <= idx + 8'd1;
            end
          end
`ifdef TS_NULL_FILL_EN
          NULL_PKT: begin
            byte_out   <= 8'hFF;
            byte_valid <= 1'b1;
            sop        <= 1'b0;
            underrun   <= 1'b0;
            if (idx == LAST_IDX) begin
              idx   <= 8'd0;
              state <= IDLE;
            end else begin
              idx <= idx + 8'd1;
            end
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
